// File: rtl/dds_pkg.sv
// dds_pkg: shared enums for the multi-channel DDS (waveform mode, config select, control FSM state)
package dds_pkg;
  typedef enum logic [1:0] {PULSE, SAW, TRI, SQUARE} mode_e;
  typedef enum logic [1:0] {SEL_TUNE, SEL_OFFSET, SEL_DUTY, SEL_MODE} sel_e;
  typedef enum logic {IDLE, APPLY} state_e;
endpackage

// File: rtl/dds_ch.sv
// dds_ch: one DDS channel with shadow/active config, phase accumulator, offset, waveform shaper, output register
// Ports: clk/rst; en advances the accumulator; wr_en/wr_sel/wr_data write a shadow register;
// apply copies shadow to active; clr (with apply) zeroes the accumulator; sig is the shaped sample; wrap pulses on overflow.
module dds_ch import dds_pkg::*; #(
  parameter int BITWIDTH = 32,
  parameter int TUNE_WIDTH = 16,
  parameter int PA_WIDTH = 23,
  parameter int PA_OUT_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr_en,
  input  sel_e                  wr_sel,
  input  logic [TUNE_WIDTH-1:0] wr_data,
  input  logic                  apply,
  input  logic                  clr,
  output logic [BITWIDTH-1:0]   sig,
  output logic                  wrap
);
  localparam int SH = BITWIDTH - PA_OUT_WIDTH;
  localparam logic [PA_OUT_WIDTH-1:0] DUTY_RST = PA_OUT_WIDTH'(1) << (PA_OUT_WIDTH - 1);
  logic [TUNE_WIDTH-1:0] sh_tune, tune;
  logic [PA_OUT_WIDTH-1:0] sh_off, off, sh_duty, duty, phase, tri_p;
  mode_e sh_mode, mode;
  logic [PA_WIDTH-1:0] acc;
  logic [PA_WIDTH:0] sum;
  logic [BITWIDTH-1:0] shaped;
  assign sum = {1'b0, acc} + (PA_WIDTH + 1)'(tune);
  assign phase = acc[PA_WIDTH-1 -: PA_OUT_WIDTH] + off;
  // fold the upper half of the phase back down so the ramp goes up then down
  assign tri_p = (phase[PA_OUT_WIDTH-1] ? ~phase : phase) << 1;
  always_comb
    shaped = mode == PULSE ? {BITWIDTH{phase < duty}} :
             mode == SAW   ? BITWIDTH'(phase) << SH :
             mode == TRI   ? BITWIDTH'(tri_p) << SH :
                             {BITWIDTH{~phase[PA_OUT_WIDTH-1]}};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh_tune <= '0;
      sh_off <= '0;
      sh_duty <= DUTY_RST;
      sh_mode <= PULSE;
      tune <= '0;
      off <= '0;
      duty <= DUTY_RST;
      mode <= PULSE;
      acc <= '0;
      wrap <= 1'b0;
      sig <= '0;
    end else begin
      if (wr_en && wr_sel == SEL_TUNE) sh_tune <= wr_data;
      if (wr_en && wr_sel == SEL_OFFSET) sh_off <= wr_data[PA_OUT_WIDTH-1:0];
      if (wr_en && wr_sel == SEL_DUTY) sh_duty <= wr_data[PA_OUT_WIDTH-1:0];
      if (wr_en && wr_sel == SEL_MODE) sh_mode <= mode_e'(wr_data[1:0]);
      if (apply) begin
        tune <= sh_tune;
        off <= sh_off;
        duty <= sh_duty;
        mode <= sh_mode;
      end
      if (apply && clr) begin
        acc <= '0;
        wrap <= 1'b0;
      end else if (en) {wrap, acc} <= sum;
      else wrap <= 1'b0;
      sig <= shaped;
    end
endmodule

// File: rtl/dds_mc.sv
// dds_mc: multi-channel DDS with shadowed configuration and atomic commit across all channels
// Ports: clk/RST; en advances all accumulators; cfg_valid/cfg_ready/cfg_ch/cfg_sel/cfg_data write shadow config;
// commit (qualified by cfg_ready) applies shadows, commit_clr also zeroes accumulators;
// sig_out packs channel samples, sig_valid flags samples from enabled cycles, wrap pulses per channel on overflow.
module dds_mc import dds_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int BITWIDTH = 32,
  parameter int TUNE_WIDTH = 16,
  parameter int PA_WIDTH = 23,
  parameter int PA_OUT_WIDTH = 14,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         en,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [CW-1:0]                cfg_ch,
  input  logic [1:0]                   cfg_sel,
  input  logic [TUNE_WIDTH-1:0]        cfg_data,
  input  logic                         commit,
  input  logic                         commit_clr,
  output logic [NUM_CH*BITWIDTH-1:0]   sig_out,
  output logic                         sig_valid,
  output logic [NUM_CH-1:0]            wrap
);
  state_e state, next;
  logic clr_q, v1, wr;
  assign wr = cfg_valid && cfg_ready;
  always_comb next = state == IDLE && commit && cfg_ready ? APPLY : IDLE;
  // cfg_ready is registered so it stays low during reset and rises one edge after release
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      state <= IDLE;
      cfg_ready <= 1'b0;
      clr_q <= 1'b0;
      v1 <= 1'b0;
      sig_valid <= 1'b0;
    end else begin
      state <= next;
      cfg_ready <= next == IDLE;
      if (commit && cfg_ready) clr_q <= commit_clr;
      v1 <= en;
      sig_valid <= v1;
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dds_ch #(
      .BITWIDTH(BITWIDTH),
      .TUNE_WIDTH(TUNE_WIDTH),
      .PA_WIDTH(PA_WIDTH),
      .PA_OUT_WIDTH(PA_OUT_WIDTH)
    ) u_ch (
      .clk(clk),
      .rst(RST),
      .en(en),
      .wr_en(wr && cfg_ch == CW'(i)),
      .wr_sel(sel_e'(cfg_sel)),
      .wr_data(cfg_data),
      .apply(state == APPLY),
      .clr(clr_q),
      .sig(sig_out[i*BITWIDTH +: BITWIDTH]),
      .wrap(wrap[i])
    );
  end
endmodule

// File: tb/tb_dds_mc.sv
// tb_dds_mc: scoreboard bench for dds_mc against an arithmetic reference model
module tb_dds_mc;
  localparam int NC = 4, BW = 32, TW = 16, PA = 23, PO = 14, W = NC * BW;
  logic clk = 0, RST = 1, en = 0, cfg_valid = 0, commit = 0, commit_clr = 0;
  logic cfg_ready, sig_valid;
  logic [1:0] cfg_ch = 0, cfg_sel = 0;
  logic [TW-1:0] cfg_data = 0;
  logic [W-1:0] sig_out;
  logic [NC-1:0] wrap;
  int tests = 0, fails = 0;
  int m_acc[NC], sh_t[NC], sh_o[NC], sh_d[NC], sh_m[NC], a_t[NC], a_o[NC], a_d[NC], a_m[NC];
  bit m_apply, m_clr, m_ready, m_v1;
  logic [W-1:0] q[$];

  dds_mc dut (
    .clk(clk), .RST(RST), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .commit(commit),
    .commit_clr(commit_clr), .sig_out(sig_out), .sig_valid(sig_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] shape(int acc, int off, int duty, int mode);
    int p, h, t;
    p = (acc / (1 << (PA - PO)) + off) % (1 << PO);
    h = 1 << (PO - 1);
    t = (p < h ? 2 * p : 2 * ((1 << PO) - 1 - p)) % (1 << PO);
    if (mode == 0) return p < duty ? '1 : '0;
    if (mode == 1) return BW'(longint'(p) * (longint'(1) << (BW - PO)));
    if (mode == 2) return BW'(longint'(t) * (longint'(1) << (BW - PO)));
    return p < h ? '1 : '0;
  endfunction

  task automatic reset_model();
    for (int n = 0; n < NC; n++) begin
      m_acc[n] = 0; sh_t[n] = 0; sh_o[n] = 0; sh_d[n] = 1 << (PO - 1); sh_m[n] = 0;
      a_t[n] = 0; a_o[n] = 0; a_d[n] = 1 << (PO - 1); a_m[n] = 0;
    end
    m_apply = 0; m_clr = 0; m_ready = 0; m_v1 = 0;
    q.delete();
  endtask

  task automatic step();
    logic [W-1:0] s;
    logic [NC-1:0] w;
    bit acc_ok;
    w = '0;
    for (int n = 0; n < NC; n++) s[n*BW +: BW] = shape(m_acc[n], a_o[n], a_d[n], a_m[n]);
    for (int n = 0; n < NC; n++)
      if (m_apply && m_clr) m_acc[n] = 0;
      else if (en) begin
        m_acc[n] += a_t[n];
        w[n] = m_acc[n] >= (1 << PA);
        m_acc[n] %= (1 << PA);
      end
    if (m_apply)
      for (int n = 0; n < NC; n++) begin
        a_t[n] = sh_t[n]; a_o[n] = sh_o[n]; a_d[n] = sh_d[n]; a_m[n] = sh_m[n];
      end
    if (cfg_valid && m_ready && int'(cfg_ch) < NC)
      case (cfg_sel)
        0: sh_t[cfg_ch] = int'(cfg_data);
        1: sh_o[cfg_ch] = int'(cfg_data) % (1 << PO);
        2: sh_d[cfg_ch] = int'(cfg_data) % (1 << PO);
        default: sh_m[cfg_ch] = int'(cfg_data) % 4;
      endcase
    acc_ok = commit && m_ready;
    if (acc_ok) m_clr = commit_clr;
    m_apply = acc_ok;
    m_ready = !acc_ok;
    if (m_v1) q.push_back(s);
    m_v1 = en;
    @(posedge clk); #1;
    chk("wrap", W'(wrap), W'(w));
    chk("cfg_ready", W'(cfg_ready), W'(m_ready));
  endtask

  task automatic idle();
    cfg_valid = 0; commit = 0; commit_clr = 0;
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    bit ok;
    int k = 0;
    cfg_valid = 1; cfg_ch = 2'(ch); cfg_sel = 2'(sel); cfg_data = TW'(data);
    do begin ok = m_ready; step(); k++; end while (!ok && k < 8);
    cfg_valid = 0;
  endtask

  task automatic cmt(input bit clr);
    bit ok;
    int k = 0;
    commit = 1; commit_clr = clr;
    do begin ok = m_ready; step(); k++; end while (!ok && k < 8);
    commit = 0; commit_clr = 0;
  endtask

  always @(negedge clk)
    if (!RST && sig_valid) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sig_valid_unexpected: got sig_valid=1 required no sample pending at %0t", $time);
      end else chk("sig_out", sig_out, q.pop_front());
    end

  initial begin
    int k;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sig_out", sig_out, '0);
    chk("rst_wrap", W'(wrap), '0);
    chk("rst_sig_valid", W'(sig_valid), '0);
    chk("rst_cfg_ready", W'(cfg_ready), '0);
    RST = 0;
    chk("cfg_ready_before_edge", W'(cfg_ready), '0);
    step();
    wr(0, 0, 512); wr(0, 3, 1); cmt(0); step();
    en = 1;
    repeat (6) step();
    en = 0;
    wr(1, 0, 16'hFFFF); cmt(1); step();
    en = 1;
    k = 0;
    do begin step(); k++; end while (!wrap[1] && k < 200);
    chk("wrap1_first_add", W'(k), W'(129));
    repeat (20) step();
    commit = 1; commit_clr = 1; step();
    step();
    idle();
    repeat (4) step();
    wr(2, 0, 512); wr(2, 2, 16'h1000); wr(2, 3, 0); cmt(1); step();
    repeat (16400) step();
    wr(0, 0, 1000); wr(3, 0, 3000);
    repeat (4) step();
    cmt(0);
    repeat (4) step();
    cfg_valid = 1; cfg_ch = 3; cfg_sel = 3; cfg_data = 2; commit = 1;
    step();
    idle();
    repeat (3) step();
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(0, 3) != 0;
      cfg_valid = $urandom_range(0, 2) == 0;
      cfg_ch = 2'($urandom_range(0, NC - 1));
      cfg_sel = 2'($urandom_range(0, 3));
      cfg_data = cfg_sel == 0 ? ($urandom_range(0, 1) != 0 ? TW'($urandom) : TW'($urandom_range(0, 2048))) : TW'($urandom);
      commit = $urandom_range(0, 9) == 0;
      commit_clr = $urandom_range(0, 2) == 0;
      step();
    end
    idle();
    en = 1;
    repeat (3) step();
    cmt(0);
    #2 RST = 1;
    #1;
    chk("async_rst_sig_out", sig_out, '0);
    chk("async_rst_wrap", W'(wrap), '0);
    chk("async_rst_sig_valid", W'(sig_valid), '0);
    chk("async_rst_cfg_ready", W'(cfg_ready), '0);
    reset_model();
    en = 0;
    @(posedge clk); #1;
    RST = 0;
    chk("cfg_ready_after_release", W'(cfg_ready), '0);
    step();
    wr(1, 0, 700); cmt(0); step();
    en = 1;
    repeat (10) step();
    en = 0;
    repeat (3) step();
    @(negedge clk); #1;
    chk("scoreboard_drained", W'(q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
